// File: rtl/settings_bus_arbiter.sv
// Two-port arbiter in front of the single settings-memory port: one access in
// flight, round-robin or fixed priority, read data returned after READ_LATENCY.
module settings_bus_arbiter #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 16,
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  wen0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id,
  output logic [7:0]            conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] RD_LAT = 3'(READ_LATENCY);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  wen_lat_q, wen_lat_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [7:0]            conflict_q, conflict_d;
  logic                  win;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wen_lat_d    = wen_lat_q;
    mem_wen_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    conflict_d   = conflict_q;
    // A lone requester wins outright; a tie goes by mode.
    if (req0 && req1) win = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant_q;
    else              win = req1;

    case (state_q)
      IDLE: begin
        if (req0 && req1) conflict_d = sat_inc8(conflict_q);
        if (req0 || req1) begin
          grant_d      = win;
          last_grant_d = win;
          busy_d       = 1'b1;
          mem_addr_d   = win ? addr1  : addr0;
          mem_wdata_d  = win ? wdata1 : wdata0;
          wen_lat_d    = win ? wen1   : wen0;
          mem_wen_d    = win ? wen1   : wen0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (wen_lat_q) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = ACK;
        end else begin
          cnt_d   = RD_LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Last wait cycle: memory output now reflects the held address.
        if (cnt_q == 3'd1) begin
          if (grant_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = ACK;
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wen_lat_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cnt_q        <= 3'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      conflict_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wen_lat_q    <= wen_lat_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      conflict_q   <= conflict_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_wen      = mem_wen_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign conflict_cnt = conflict_q;

endmodule
